// File: rtl/countdown_5bit_pkg.sv
// Shared widths, state encodings and helpers for the 5-bit countdown timer.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN.
package countdown_5bit_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Saturating decrement: the count never wraps from 0 to 31.
    function automatic logic [CNT_W-1:0] dec_sat(
        input logic [CNT_W-1:0] v
    );
        if (v == '0)
            return '0;
        else
            return v - {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/countdown_5bit_dffe_sclr.sv
// Single-bit D flip-flop with clock enable and synchronous clear.
// Clear has priority over enable.
module dffe_sclr (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/countdown_5bit.sv
// Loadable 5-bit countdown timer with IDLE/RUN/DONE control FSM.
// Build macro COUNTDOWN_AUTORELOAD_EN adds a stop input and reload register.
module countdown_5bit
    import countdown_5bit_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
`ifdef COUNTDOWN_AUTORELOAD_EN
    input  logic             stop,
`endif
    output logic [CNT_W-1:0] q,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    logic [1:0]       st_bits;
    state_t           state;
    state_t           nxt_state;
    logic             st_en;
    logic [CNT_W-1:0] q_r;
    logic [CNT_W-1:0] q_nxt;
    logic             q_en;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [CNT_W-1:0] rl;
    logic             rl_en;
`endif

    assign state = state_t'(st_bits);

    always_comb begin
        nxt_state = state;
        st_en     = 1'b0;
        q_nxt     = q_r;
        q_en      = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        rl_en     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    q_nxt = load_val;
                    q_en  = 1'b1;
                    st_en = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    rl_en = 1'b1;
`endif
                    nxt_state = (load_val == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (en) begin
                    q_nxt = dec_sat(q_r);
                    q_en  = 1'b1;
                    // q==0 cannot occur here; treat it as finished anyway
                    if (q_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        nxt_state = DONE;
                        st_en     = 1'b1;
                    end
                end
            end
            DONE: begin
                st_en = 1'b1;
                q_en  = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (stop) begin
                    q_nxt     = '0;
                    nxt_state = IDLE;
                end else begin
                    q_nxt     = rl;
                    nxt_state = (rl == '0) ? DONE : RUN;
                end
`else
                q_nxt     = '0;
                nxt_state = IDLE;
`endif
            end
            default: begin
                q_nxt     = '0;
                q_en      = 1'b1;
                nxt_state = IDLE;
                st_en     = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < 2; i++) begin : g_st
        dffe_sclr u_st (
            .clk (clk),
            .clr (clr),
            .en  (st_en),
            .d   (nxt_state[i]),
            .q   (st_bits[i])
        );
    end

    for (genvar i = 0; i < CNT_W; i++) begin : g_q
        dffe_sclr u_q (
            .clk (clk),
            .clr (clr),
            .en  (q_en),
            .d   (q_nxt[i]),
            .q   (q_r[i])
        );
    end

`ifdef COUNTDOWN_AUTORELOAD_EN
    for (genvar i = 0; i < CNT_W; i++) begin : g_rl
        dffe_sclr u_rl (
            .clk (clk),
            .clr (clr),
            .en  (rl_en),
            .d   (load_val[i]),
            .q   (rl[i])
        );
    end
`endif

    assign q     = q_r;
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_countdown_5bit.sv
// Directed self-checking bench for countdown_5bit.
// Autoreload steps are built only with COUNTDOWN_AUTORELOAD_EN.
module tb_countdown_5bit;

    logic       clk;
    logic       clr;
    logic       start;
    logic       en;
    logic [4:0] load_val;
    logic [4:0] q;
    logic       ready;
    logic       busy;
    logic       done;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic       stop;
`endif

    int checks = 0;
    int errors = 0;

    countdown_5bit dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .en       (en),
        .load_val (load_val),
`ifdef COUNTDOWN_AUTORELOAD_EN
        .stop     (stop),
`endif
        .q        (q),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected value packed as {ready, busy, done, q}
    function automatic logic [7:0] ex(
        input logic r, input logic b, input logic d, input logic [4:0] v
    );
        return {r, b, d, v};
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {ready, busy, done, q};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed rbd_q=%b expected rbd_q=%b",
                   tag, obs, exp);
        end
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        en       = 1'b0;
        load_val = 5'd0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        stop     = 1'b1;
`endif
        step();
        chk("reset", ex(1, 0, 0, 5'd0));

        // N=5 with en held high
        clr      = 1'b0;
        start    = 1'b1;
        en       = 1'b1;
        load_val = 5'd5;
        step();
        chk("n5_load", ex(0, 1, 0, 5'd5));
        start = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            step();
            chk("n5_count", ex(0, 1, 0, 5'(i)));
        end
        step();
        chk("n5_done", ex(0, 0, 1, 5'd0));
        step();
        chk("n5_idle", ex(1, 0, 0, 5'd0));

        // IDLE holds without start
        load_val = 5'd9;
        step();
        chk("idle_hold", ex(1, 0, 0, 5'd0));

        // N=0 goes straight to DONE
        start    = 1'b1;
        load_val = 5'd0;
        step();
        chk("n0_done", ex(0, 0, 1, 5'd0));
        start = 1'b0;
        step();
        chk("n0_idle", ex(1, 0, 0, 5'd0));

        // N=31, pause three cycles at q=20
        start    = 1'b1;
        load_val = 5'd31;
        step();
        chk("n31_load", ex(0, 1, 0, 5'd31));
        start = 1'b0;
        for (int i = 30; i >= 20; i--) begin
            step();
            chk("n31_count_a", ex(0, 1, 0, 5'(i)));
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("n31_pause", ex(0, 1, 0, 5'd20));
        end
        en = 1'b1;
        for (int i = 19; i >= 1; i--) begin
            step();
            chk("n31_count_b", ex(0, 1, 0, 5'(i)));
        end
        step();
        chk("n31_done", ex(0, 0, 1, 5'd0));
        step();
        chk("n31_idle", ex(1, 0, 0, 5'd0));

        // start ignored during RUN
        start    = 1'b1;
        load_val = 5'd4;
        step();
        chk("ign_load", ex(0, 1, 0, 5'd4));
        load_val = 5'd7;
        step();
        chk("ign_start", ex(0, 1, 0, 5'd3));
        start = 1'b0;
        step();
        chk("ign_q2", ex(0, 1, 0, 5'd2));
        step();
        chk("ign_q1", ex(0, 1, 0, 5'd1));
        step();
        chk("ign_done", ex(0, 0, 1, 5'd0));
        step();
        chk("ign_idle", ex(1, 0, 0, 5'd0));

        // start loads even with en low; RUN then pauses
        en       = 1'b0;
        start    = 1'b1;
        load_val = 5'd2;
        step();
        chk("en0_load", ex(0, 1, 0, 5'd2));
        start = 1'b0;
        step();
        chk("en0_hold", ex(0, 1, 0, 5'd2));
        en = 1'b1;
        step();
        chk("en0_q1", ex(0, 1, 0, 5'd1));
        step();
        chk("en0_done", ex(0, 0, 1, 5'd0));
        step();
        chk("en0_idle", ex(1, 0, 0, 5'd0));

        // clr aborts RUN at q=3 with no done pulse
        start    = 1'b1;
        load_val = 5'd6;
        step();
        chk("abort_load", ex(0, 1, 0, 5'd6));
        start = 1'b0;
        for (int i = 5; i >= 3; i--) begin
            step();
            chk("abort_count", ex(0, 1, 0, 5'(i)));
        end
        clr = 1'b1;
        step();
        chk("abort_clr", ex(1, 0, 0, 5'd0));
        clr = 1'b0;
        step();
        chk("abort_nodone", ex(1, 0, 0, 5'd0));

        // clr has priority over start
        clr      = 1'b1;
        start    = 1'b1;
        load_val = 5'd9;
        step();
        chk("clr_prio", ex(1, 0, 0, 5'd0));
        clr   = 1'b0;
        start = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload N=3: done every 4th cycle until stop
        stop     = 1'b0;
        start    = 1'b1;
        load_val = 5'd3;
        step();
        chk("ar_load", ex(0, 1, 0, 5'd3));
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step();
            chk("ar_q2", ex(0, 1, 0, 5'd2));
            step();
            chk("ar_q1", ex(0, 1, 0, 5'd1));
            step();
            chk("ar_done", ex(0, 0, 1, 5'd0));
            if (r == 1)
                stop = 1'b1;
            step();
            if (r == 0)
                chk("ar_reload", ex(0, 1, 0, 5'd3));
            else
                chk("ar_stop", ex(1, 0, 0, 5'd0));
        end
        stop = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
